// File: rtl/imsic_pkg.sv
// Shared IMSIC types and width helpers. Used by the MSI ingress gate and by
// the per-hart interrupt-file register block.
package imsic_pkg;

    // Widest field encodings any configuration produces: up to 65 interrupt
    // files and up to 2048 identities per file.
    localparam int unsigned IMSIC_FILE_W_MAX = 7;
    localparam int unsigned IMSIC_SRC_W_MAX  = 11;

    function automatic int unsigned imsic_src_width(input int unsigned nr_src);
        return $clog2(nr_src);
    endfunction

    function automatic int unsigned imsic_file_width(input int unsigned nr_files);
        return $clog2(nr_files);
    endfunction

    function automatic int unsigned imsic_msi_info_width(input int unsigned hart_w,
                                                         input int unsigned nr_files,
                                                         input int unsigned nr_src);
        return hart_w + imsic_file_width(nr_files) + imsic_src_width(nr_src);
    endfunction

    // One set/clear command toward the interrupt-file register block.
    // Fields are zero-extended from the instance widths.
    typedef struct packed {
        logic                        set;
        logic [IMSIC_FILE_W_MAX-1:0] file;
        logic [IMSIC_SRC_W_MAX-1:0]  id;
    } imsic_upd_t;

    typedef enum logic [1:0] {
        CAP_IDLE  = 2'd0,
        CAP_CHECK = 2'd1,
        CAP_HOLD  = 2'd2
    } imsic_cap_state_t;

endpackage

// File: rtl/cmip_dff_sync.sv
// Multi-flop synchronizer for slow or toggle-encoded signals crossing in
// from another clock domain. Output lags input by STAGES clk edges.
module cmip_dff_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stg;

    // Shift the input through the synchronizer chain, stage 0 first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg <= '0;
        end else begin
            stg <= {stg[STAGES-2:0], d};
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/imsic_msi_fifo.sv
// Register-based FIFO for accepted MSIs. Pointers carry one extra wrap bit
// so full and empty are told apart without a counter.
module imsic_msi_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [AW:0]                wr_ptr;
    logic [AW:0]                rd_ptr;
    logic [DEPTH-1:0][DW-1:0]   mem;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];

    // Advance pointers; a push against a full FIFO or a pop of an empty one
    // is ignored, and both may happen in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + ONE;
            if (pop && !empty) rd_ptr <= rd_ptr + ONE;
        end
    end

    // Storage needs no reset: entries are only read between the pointers.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/imsic_msi_queue_gate.sv
// IMSIC MSI ingress gate: toggle-handshake capture, legality filter,
// accepted-MSI FIFO and a claim-priority update arbiter.
// Optional: define IMSIC_MSI_DROP_CNT_EN to add the o_drop_cnt port and its
// saturating discarded-record counter.
module imsic_msi_queue_gate
    import imsic_pkg::*;
#(
    parameter int unsigned NR_INTP_FILES  = 7,
    parameter int unsigned NR_HARTS       = 4,
    parameter int unsigned NR_HARTS_WIDTH = 2,
    parameter int unsigned NR_SRC         = 256,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned SYNC_STAGES    = 3,
    localparam int unsigned NR_SRC_WIDTH    = imsic_src_width(NR_SRC),
    localparam int unsigned INTP_FILE_WIDTH = imsic_file_width(NR_INTP_FILES),
    localparam int unsigned MSI_INFO_WIDTH  = imsic_msi_info_width(NR_HARTS_WIDTH,
                                                                   NR_INTP_FILES, NR_SRC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NR_HARTS_WIDTH-1:0]  hart_id,
    input  logic [MSI_INFO_WIDTH-1:0]  i_msi_info,
    input  logic                       i_msi_req,
    output logic                       o_msi_ack,
    input  logic                       i_claim_vld,
    input  logic [INTP_FILE_WIDTH-1:0] i_claim_file,
    input  logic [NR_SRC_WIDTH-1:0]    i_claim_id,
    output logic                       o_upd_vld,
    output logic                       o_upd_set,
    output logic [INTP_FILE_WIDTH-1:0] o_upd_file,
    output logic [NR_SRC_WIDTH-1:0]    o_upd_id,
    output logic                       o_fifo_full
`ifdef IMSIC_MSI_DROP_CNT_EN
    ,
    output logic [15:0]                o_drop_cnt
`endif
);

    localparam int unsigned FIFO_DW = INTP_FILE_WIDTH + NR_SRC_WIDTH;

    // ---------------- request toggle synchronizer ----------------
    logic req_sync;
    logic req_sync_d;
    logic req_edge;

    cmip_dff_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (i_msi_req),
        .q   (req_sync)
    );

    // Delayed copy of the synchronized toggle for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_sync_d <= 1'b0;
        else     req_sync_d <= req_sync;
    end

    assign req_edge = req_sync ^ req_sync_d;

    // ---------------- capture and legality ----------------
    imsic_cap_state_t            state_q;
    imsic_cap_state_t            state_d;
    logic                        cap_load;
    logic                        push;
    logic                        ack_tgl;
    logic                        drop;
    logic [NR_HARTS_WIDTH-1:0]   cap_hart;
    logic [INTP_FILE_WIDTH-1:0]  cap_file;
    logic [NR_SRC_WIDTH-1:0]     cap_id;
    logic [NR_HARTS_WIDTH-1:0]   hart_eff;
    logic [31:0]                 file_ext;
    logic [31:0]                 id_ext;
    logic                        legal;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        ack_q;

    // The record is stable on i_msi_info until ack, so one load suffices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_hart <= '0;
            cap_file <= '0;
            cap_id   <= '0;
        end else if (cap_load) begin
            {cap_hart, cap_file, cap_id} <= i_msi_info;
        end
    end

    assign hart_eff = (NR_HARTS == 1) ? '0 : hart_id;
    assign file_ext = 32'(cap_file);
    assign id_ext   = 32'(cap_id);
    assign legal    = (cap_hart == hart_eff) && (file_ext < NR_INTP_FILES) &&
                      (cap_id != '0) && (id_ext < NR_SRC);

    // Capture FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= CAP_IDLE;
        else     state_q <= state_d;
    end

    // Capture FSM: edges outside IDLE are sender protocol errors and ignored;
    // a legal record waits in HOLD rather than being dropped.
    always_comb begin
        state_d  = state_q;
        cap_load = 1'b0;
        push     = 1'b0;
        ack_tgl  = 1'b0;
        drop     = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                if (req_edge) begin
                    cap_load = 1'b1;
                    state_d  = CAP_CHECK;
                end
            end
            CAP_CHECK: begin
                if (!legal) begin
                    drop    = 1'b1;
                    ack_tgl = 1'b1;
                    state_d = CAP_IDLE;
                end else if (!fifo_full) begin
                    push    = 1'b1;
                    ack_tgl = 1'b1;
                    state_d = CAP_IDLE;
                end else begin
                    state_d = CAP_HOLD;
                end
            end
            CAP_HOLD: begin
                if (!fifo_full) begin
                    push    = 1'b1;
                    ack_tgl = 1'b1;
                    state_d = CAP_IDLE;
                end
            end
            default: state_d = CAP_IDLE;
        endcase
    end

    // Acknowledge toggle, one flip per consumed request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ack_q <= 1'b0;
        else     ack_q <= ack_q ^ ack_tgl;
    end

    assign o_msi_ack = ack_q;

    // ---------------- accepted-MSI FIFO ----------------
    logic               pop;
    logic [FIFO_DW-1:0] head;

    imsic_msi_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (FIFO_DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({cap_file, cap_id}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_fifo_full = fifo_full;

    // ---------------- update arbiter ----------------
    imsic_upd_t upd_d;
    imsic_upd_t upd_q;
    logic       upd_vld_q;

    // Claims win; the FIFO head stays put until a claim-free cycle.
    always_comb begin
        upd_d = '0;
        pop   = 1'b0;
        if (i_claim_vld) begin
            upd_d.set  = 1'b0;
            upd_d.file = IMSIC_FILE_W_MAX'(i_claim_file);
            upd_d.id   = IMSIC_SRC_W_MAX'(i_claim_id);
        end else if (!fifo_empty) begin
            pop        = 1'b1;
            upd_d.set  = 1'b1;
            upd_d.file = IMSIC_FILE_W_MAX'(head[NR_SRC_WIDTH +: INTP_FILE_WIDTH]);
            upd_d.id   = IMSIC_SRC_W_MAX'(head[NR_SRC_WIDTH-1:0]);
        end
    end

    // Register one update command per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_vld_q <= 1'b0;
            upd_q     <= '0;
        end else begin
            upd_vld_q <= i_claim_vld || !fifo_empty;
            upd_q     <= upd_d;
        end
    end

    assign o_upd_vld  = upd_vld_q;
    assign o_upd_set  = upd_q.set;
    assign o_upd_file = upd_q.file[INTP_FILE_WIDTH-1:0];
    assign o_upd_id   = upd_q.id[NR_SRC_WIDTH-1:0];

    // Field bits above this instance's widths are always zero.
    logic unused_upd_bits;
    assign unused_upd_bits = ^{upd_q.file, upd_q.id};

`ifdef IMSIC_MSI_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    // Saturating count of discarded (illegal) records.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    assign o_drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_imsic_msi_queue_gate.sv
// Directed bench for imsic_msi_queue_gate (default parameters).
// Build with IMSIC_MSI_DROP_CNT_EN to also check o_drop_cnt.
module tb_imsic_msi_queue_gate;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  hart_id;
    logic [12:0] i_msi_info;
    logic        i_msi_req;
    logic        o_msi_ack;
    logic        i_claim_vld;
    logic [2:0]  i_claim_file;
    logic [7:0]  i_claim_id;
    logic        o_upd_vld;
    logic        o_upd_set;
    logic [2:0]  o_upd_file;
    logic [7:0]  o_upd_id;
    logic        o_fifo_full;
`ifdef IMSIC_MSI_DROP_CNT_EN
    logic [15:0] o_drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    imsic_msi_queue_gate dut (
        .clk          (clk),
        .rst          (rst),
        .hart_id      (hart_id),
        .i_msi_info   (i_msi_info),
        .i_msi_req    (i_msi_req),
        .o_msi_ack    (o_msi_ack),
        .i_claim_vld  (i_claim_vld),
        .i_claim_file (i_claim_file),
        .i_claim_id   (i_claim_id),
        .o_upd_vld    (o_upd_vld),
        .o_upd_set    (o_upd_set),
        .o_upd_file   (o_upd_file),
        .o_upd_id     (o_upd_id),
        .o_fifo_full  (o_fifo_full)
`ifdef IMSIC_MSI_DROP_CNT_EN
        ,
        .o_drop_cnt   (o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    logic [10:0] set_q[$];
    int          clr_cnt     = 0;
    int          ack_tgl_cnt = 0;
    logic        ack_prev    = 1'b0;
    logic        full_seen   = 1'b0;

    always @(negedge clk) begin
        if (o_upd_vld === 1'b1 && o_upd_set === 1'b1) set_q.push_back({o_upd_file, o_upd_id});
        if (o_upd_vld === 1'b1 && o_upd_set === 1'b0) clr_cnt++;
        if (o_msi_ack !== ack_prev) ack_tgl_cnt++;
        ack_prev = o_msi_ack;
        if (o_fifo_full === 1'b1) full_seen = 1'b1;
    end

    task automatic clear_mon();
        @(posedge clk);
        #1;
        set_q.delete();
        clr_cnt     = 0;
        ack_tgl_cnt = 0;
        full_seen   = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_msi(input logic [1:0] h, input logic [2:0] f, input logic [7:0] id);
        i_msi_info = {h, f, id};
        i_msi_req  = ~i_msi_req;
    endtask

    task automatic wait_ack(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (o_msi_ack === i_msi_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        total++; if (o_msi_ack !== 1'b0)   begin bad++; $display("FAIL reset_ack got=%b exp=0", o_msi_ack); end
        total++; if (o_upd_vld !== 1'b0)   begin bad++; $display("FAIL reset_vld got=%b exp=0", o_upd_vld); end
        total++; if ({o_upd_set, o_upd_file, o_upd_id} !== 12'h000)
            begin bad++; $display("FAIL reset_upd got=%h exp=000", {o_upd_set, o_upd_file, o_upd_id}); end
        total++; if (o_fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", o_fifo_full); end
`ifdef IMSIC_MSI_DROP_CNT_EN
        total++; if (o_drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", o_drop_cnt); end
`endif
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_latency();
        int   first = 0;
        int   ack_k = 0;
        logic s;
        logic [2:0] f;
        logic [7:0] id;
        clear_mon();
        send_msi(2'd1, 3'd2, 8'd37);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (first == 0 && o_upd_vld === 1'b1) begin
                first = k; s = o_upd_set; f = o_upd_file; id = o_upd_id;
            end
            if (ack_k == 0 && o_msi_ack === i_msi_req) ack_k = k;
        end
        total++; if (first != 6)  begin bad++; $display("FAIL lat_cycles got=%0d exp=6", first); end
        total++; if (s !== 1'b1)  begin bad++; $display("FAIL lat_set got=%b exp=1", s); end
        total++; if (f !== 3'd2)  begin bad++; $display("FAIL lat_file got=%0d exp=2", f); end
        total++; if (id !== 8'd37) begin bad++; $display("FAIL lat_id got=%0d exp=37", id); end
        total++; if (ack_k != 5)  begin bad++; $display("FAIL lat_ack_cycle got=%0d exp=5", ack_k); end
        total++; if (ack_tgl_cnt != 1) begin bad++; $display("FAIL lat_ack_toggles got=%0d exp=1", ack_tgl_cnt); end
        total++; if (set_q.size() != 1) begin bad++; $display("FAIL lat_upd_count got=%0d exp=1", set_q.size()); end
    endtask

    task automatic test_illegal();
        bit ok;
        clear_mon();
        send_msi(2'd1, 3'd0, 8'd0);   // reserved id 0
        wait_ack(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL ill_id0_ack got=timeout exp=ack"); end
        send_msi(2'd1, 3'd7, 8'd4);   // file == NR_INTP_FILES
        wait_ack(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL ill_file_ack got=timeout exp=ack"); end
        send_msi(2'd2, 3'd1, 8'd4);   // other hart
        wait_ack(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL ill_hart_ack got=timeout exp=ack"); end
        idle(8);
        total++; if (set_q.size() != 0) begin bad++; $display("FAIL ill_no_upd got=%0d exp=0", set_q.size()); end
        total++; if (ack_tgl_cnt != 3) begin bad++; $display("FAIL ill_ack_toggles got=%0d exp=3", ack_tgl_cnt); end
`ifdef IMSIC_MSI_DROP_CNT_EN
        total++; if (o_drop_cnt !== 16'd3) begin bad++; $display("FAIL ill_drop_cnt got=%0d exp=3", o_drop_cnt); end
`endif
        // Highest legal file and identity are accepted.
        clear_mon();
        send_msi(2'd1, 3'd6, 8'd255);
        wait_ack(40, ok);
        idle(6);
        total++; if (set_q.size() != 1 || set_q[0] !== {3'd6, 8'd255})
            begin bad++; $display("FAIL edge_legal got_n=%0d exp={6,255}", set_q.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        i_claim_file = 3'd1;
        i_claim_id   = 8'd9;
        i_claim_vld  = 1'b1;
        clear_mon();
        for (int i = 0; i < 4; i++) begin
            send_msi(2'd1, 3'd0, 8'(10 + i));
            wait_ack(40, ok);
            total++; if (!ok) begin bad++; $display("FAIL bp_ack%0d got=timeout exp=ack", i); end
        end
        send_msi(2'd1, 3'd0, 8'd14);
        idle(20);
        total++; if (o_msi_ack === i_msi_req) begin bad++; $display("FAIL bp_ack_held got=acked exp=withheld"); end
        total++; if (o_fifo_full !== 1'b1) begin bad++; $display("FAIL bp_full got=%b exp=1", o_fifo_full); end
        total++; if (set_q.size() != 0) begin bad++; $display("FAIL bp_no_set got=%0d exp=0", set_q.size()); end
        total++; if (clr_cnt < 20) begin bad++; $display("FAIL bp_claims got=%0d exp>=20", clr_cnt); end
        i_claim_vld = 1'b0;
        wait_ack(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_ack_release got=timeout exp=ack"); end
        send_msi(2'd1, 3'd0, 8'd15);
        wait_ack(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_ack_last got=timeout exp=ack"); end
        idle(12);
        total++; if (set_q.size() != 6) begin bad++; $display("FAIL bp_count got=%0d exp=6", set_q.size()); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (i >= set_q.size() || set_q[i] !== {3'd0, 8'(10 + i)})
                begin bad++; $display("FAIL bp_order%0d got=%h exp=%h", i,
                      (i < set_q.size()) ? set_q[i] : 11'h7ff, {3'd0, 8'(10 + i)}); end
        end
        total++; if (o_fifo_full !== 1'b0) begin bad++; $display("FAIL bp_full_clear got=%b exp=0", o_fifo_full); end
    endtask

    task automatic test_claim_vs_head();
        logic       v[9];
        logic [11:0] u[9];
        clear_mon();
        i_claim_file = 3'd0;
        i_claim_id   = 8'd5;
        send_msi(2'd1, 3'd0, 8'd5);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            v[k] = o_upd_vld;
            u[k] = {o_upd_set, o_upd_file, o_upd_id};
            i_claim_vld = (k == 5);
        end
        total++; if (v[5] !== 1'b0) begin bad++; $display("FAIL cvh_idle got=%b exp=0", v[5]); end
        total++; if (v[6] !== 1'b1 || u[6] !== {1'b0, 3'd0, 8'd5})
            begin bad++; $display("FAIL cvh_clear got=%b/%h exp=1/%h", v[6], u[6], {1'b0, 3'd0, 8'd5}); end
        total++; if (v[7] !== 1'b1 || u[7] !== {1'b1, 3'd0, 8'd5})
            begin bad++; $display("FAIL cvh_set got=%b/%h exp=1/%h", v[7], u[7], {1'b1, 3'd0, 8'd5}); end
        total++; if (v[8] !== 1'b0) begin bad++; $display("FAIL cvh_after got=%b exp=0", v[8]); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_mon();
        for (int i = 0; i < 8; i++) begin
            send_msi(2'd1, 3'(i % 7), 8'(20 + i));
            wait_ack(40, ok);
            total++; if (!ok) begin bad++; $display("FAIL b2b_ack%0d got=timeout exp=ack", i); end
        end
        idle(8);
        total++; if (set_q.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", set_q.size()); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (i >= set_q.size() || set_q[i] !== {3'(i % 7), 8'(20 + i)})
                begin bad++; $display("FAIL b2b_order%0d got=%h exp=%h", i,
                      (i < set_q.size()) ? set_q[i] : 11'h7ff, {3'(i % 7), 8'(20 + i)}); end
        end
        total++; if (full_seen !== 1'b0) begin bad++; $display("FAIL b2b_never_full got=%b exp=0", full_seen); end
    endtask

    task automatic test_reset_hold();
        bit ok;
        i_claim_file = 3'd2;
        i_claim_id   = 8'd1;
        i_claim_vld  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_msi(2'd1, 3'd1, 8'(40 + i));
            wait_ack(40, ok);
        end
        send_msi(2'd1, 3'd1, 8'd44);
        idle(10);
        total++; if (o_fifo_full !== 1'b1 || o_msi_ack === i_msi_req)
            begin bad++; $display("FAIL rh_setup got=full%b exp=full1_held", o_fifo_full); end
        rst         = 1'b1;
        i_msi_req   = 1'b0;
        i_msi_info  = '0;
        i_claim_vld = 1'b0;
        idle(2);
        total++; if (o_msi_ack !== 1'b0) begin bad++; $display("FAIL rh_ack got=%b exp=0", o_msi_ack); end
        total++; if (o_upd_vld !== 1'b0 || {o_upd_set, o_upd_file, o_upd_id} !== 12'h000)
            begin bad++; $display("FAIL rh_upd got=%b/%h exp=0/000", o_upd_vld, {o_upd_set, o_upd_file, o_upd_id}); end
        total++; if (o_fifo_full !== 1'b0) begin bad++; $display("FAIL rh_full got=%b exp=0", o_fifo_full); end
`ifdef IMSIC_MSI_DROP_CNT_EN
        total++; if (o_drop_cnt !== 16'd0) begin bad++; $display("FAIL rh_drop got=%0d exp=0", o_drop_cnt); end
`endif
        rst = 1'b0;
        idle(2);
        clear_mon();
        send_msi(2'd1, 3'd3, 8'd77);
        wait_ack(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL rh_post_ack got=timeout exp=ack"); end
        idle(8);
        total++; if (set_q.size() != 1 || set_q[0] !== {3'd3, 8'd77})
            begin bad++; $display("FAIL rh_post_upd got_n=%0d exp={3,77}", set_q.size()); end
    endtask

    initial begin
        rst          = 1'b1;
        hart_id      = 2'd1;
        i_msi_info   = '0;
        i_msi_req    = 1'b0;
        i_claim_vld  = 1'b0;
        i_claim_file = '0;
        i_claim_id   = '0;
        test_reset();
        test_latency();
        test_illegal();
        test_backpressure();
        test_claim_vs_head();
        test_back_to_back();
        test_reset_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
